// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: memory op encodings, FSM states and
// the small decode helpers used by both the stage and its lane aligner.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    OpNone = 4'd0,
    OpLb   = 4'd1,
    OpLbu  = 4'd2,
    OpLh   = 4'd3,
    OpLhu  = 4'd4,
    OpLw   = 4'd5,
    OpSb   = 4'd6,
    OpSh   = 4'd7,
    OpSw   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoadWait,
    StRmwMerge
  } state_t;

  localparam logic [1:0] ACCESS_WORD = 2'b00;

  function automatic logic is_misaligned(mem_op_t op, logic [1:0] lo);
    case (op)
      OpLh, OpLhu, OpSh: is_misaligned = lo[0];
      OpLw, OpSw:        is_misaligned = |lo;
      default:           is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic is_sub_store(mem_op_t op);
    is_sub_store = (op == OpSb) || (op == OpSh);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane handling: extracts/extends load data from a memory word and
// merges a byte/halfword of store data into a word for read-modify-write.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [15:0] store_half,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    unique case (lane)
      2'd0: byte_sel = word[31:24];
      2'd1: byte_sel = word[23:16];
      2'd2: byte_sel = word[15:8];
      2'd3: byte_sel = word[7:0];
    endcase
    half_sel = lane[1] ? word[15:0] : word[31:16];

    load_data = word;
    case (op)
      OpLb:    load_data = {{24{byte_sel[7]}}, byte_sel};
      OpLbu:   load_data = {24'h000000, byte_sel};
      OpLh:    load_data = {{16{half_sel[15]}}, half_sel};
      OpLhu:   load_data = {16'h0000, half_sel};
      default: load_data = word;
    endcase

    merge_data = word;
    case (op)
      OpSb: begin
        unique case (lane)
          2'd0: merge_data[31:24] = store_half[7:0];
          2'd1: merge_data[23:16] = store_half[7:0];
          2'd2: merge_data[15:8]  = store_half[7:0];
          2'd3: merge_data[7:0]   = store_half[7:0];
        endcase
      end
      OpSh: begin
        if (lane[1]) merge_data[15:0] = store_half;
        else         merge_data[31:16] = store_half;
      end
      default: merge_data = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: maps byte/half/word loads and stores onto a word-only memory,
// doing sub-word stores as read-modify-write and registering results toward WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h80020000,
  parameter int unsigned MEM_BYTES = 1048576
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        wb_fwd,
  input  logic [31:0] wb_fwd_data,
  input  logic        flush,
  output logic        mem_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_access_size,
  output logic        mem_rw,
  output logic        mem_enable,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_result,
  output logic        addr_err
);

  state_t      state_q, state_d;
  mem_op_t     op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] sdata_q, sdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;

  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic [31:0] wb_result_q, wb_result_d;
  logic        addr_err_q, addr_err_d;

  mem_op_t     ex_op;
  logic [31:0] store_data;
  logic [31:0] ex_offset;
  logic        in_range;
  logic        accept;
  logic        err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign ex_op      = mem_op_t'(ex_mem_op);
  assign store_data = wb_fwd ? wb_fwd_data : ex_store_data;
  assign ex_offset  = ex_addr - BASE_ADDR;
  assign in_range   = (ex_addr >= BASE_ADDR) && (ex_offset < MEM_BYTES);
  assign accept     = (state_q == StIdle) && ex_valid && !flush;
  assign err        = (ex_op != OpNone) && (is_misaligned(ex_op, ex_addr[1:0]) || !in_range);

  // Only the multi-cycle states need alignment, so it always works on held state.
  mem_lane_align u_lane_align (
    .op         (op_q),
    .lane       (addr_q[1:0]),
    .word       (mem_rdata),
    .store_half (sdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    sdata_d        = sdata_q;
    rd_d           = rd_q;
    reg_write_d    = reg_write_q;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = 1'b0;
    wb_result_d    = wb_result_q;
    addr_err_d     = 1'b0;
    mem_enable     = 1'b0;
    mem_rw         = 1'b1;
    mem_addr       = {ex_addr[31:2], 2'b00};
    mem_wdata      = store_data;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          wb_rd_d = ex_rd;
          if (err) begin
            wb_valid_d = 1'b1;
            addr_err_d = 1'b1;
          end else if (ex_op == OpNone) begin
            wb_valid_d     = 1'b1;
            wb_result_d    = ex_addr;
            wb_reg_write_d = ex_reg_write;
          end else if (ex_op == OpSw) begin
            mem_enable = 1'b1;
            mem_rw     = 1'b0;
            wb_valid_d = 1'b1;
          end else begin
            // Loads and sub-word stores both start with a word read.
            mem_enable  = 1'b1;
            op_d        = ex_op;
            addr_d      = ex_addr;
            sdata_d     = store_data[15:0];
            rd_d        = ex_rd;
            reg_write_d = ex_reg_write;
            state_d     = is_sub_store(ex_op) ? StRmwMerge : StLoadWait;
          end
        end
      end
      StLoadWait: begin
        mem_addr       = {addr_q[31:2], 2'b00};
        state_d        = StIdle;
        wb_valid_d     = !flush;
        wb_reg_write_d = reg_write_q && !flush;
        wb_rd_d        = rd_q;
        if (!flush) wb_result_d = load_data;
      end
      StRmwMerge: begin
        // A flush here is ignored: the store was committed at accept.
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_enable = 1'b1;
        mem_rw     = 1'b0;
        mem_wdata  = merge_data;
        state_d    = StIdle;
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      op_q           <= OpNone;
      addr_q         <= '0;
      sdata_q        <= '0;
      rd_q           <= '0;
      reg_write_q    <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      wb_result_q    <= '0;
      addr_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      sdata_q        <= sdata_d;
      rd_q           <= rd_d;
      reg_write_q    <= reg_write_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_result_q    <= wb_result_d;
      addr_err_q     <= addr_err_d;
    end
  end

  assign mem_stall       = (state_q != StIdle);
  assign mem_access_size = ACCESS_WORD;
  assign wb_valid        = wb_valid_q;
  assign wb_rd           = wb_rd_q;
  assign wb_reg_write    = wb_reg_write_q;
  assign wb_result       = wb_result_q;
  assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a small word memory behind it; all
// expected values are hand-computed constants.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [31:0] Base = 32'h80020000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        wb_fwd;
  logic [31:0] wb_fwd_data;
  logic        flush;
  logic        mem_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_access_size;
  logic        mem_rw;
  logic        mem_enable;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_result;
  logic        addr_err;

  int n_checks = 0;
  int n_pass   = 0;

  mem_stage dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .ex_valid        (ex_valid),
    .ex_mem_op       (ex_mem_op),
    .ex_addr         (ex_addr),
    .ex_store_data   (ex_store_data),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .wb_fwd          (wb_fwd),
    .wb_fwd_data     (wb_fwd_data),
    .flush           (flush),
    .mem_stall       (mem_stall),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_access_size (mem_access_size),
    .mem_rw          (mem_rw),
    .mem_enable      (mem_enable),
    .mem_rdata       (mem_rdata),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .wb_reg_write    (wb_reg_write),
    .wb_result       (wb_result),
    .addr_err        (addr_err)
  );

  always #5 clock = ~clock;

  // 16-word data memory at Base, registered read/write.
  logic [31:0] mem [16];
  logic [3:0]  mem_idx;
  logic        mem_hit;
  assign mem_idx = mem_addr[5:2];
  assign mem_hit = (mem_addr[31:6] == Base[31:6]);

  always @(posedge clock) begin
    if (mem_enable && mem_hit) begin
      if (mem_rw) mem_rdata <= mem[mem_idx];
      else        mem[mem_idx] <= mem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input mem_op_t op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] rd, input logic regw, input logic fwd,
                       input logic [31:0] fwdd, input logic fl);
    ex_valid      = 1'b1;
    ex_mem_op     = op;
    ex_addr       = addr;
    ex_store_data = sdata;
    ex_rd         = rd;
    ex_reg_write  = regw;
    wb_fwd        = fwd;
    wb_fwd_data   = fwdd;
    flush         = fl;
  endtask

  task automatic idle_in();
    ex_valid  = 1'b0;
    ex_mem_op = OpNone;
    wb_fwd    = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_load(input string tag, input mem_op_t op, input logic [31:0] addr,
                         input logic [31:0] exp);
    drive(op, addr, 32'h0, 5'd7, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check_eq({tag, "_en"}, {31'h0, mem_enable}, 32'h1);
    check_eq({tag, "_rw"}, {31'h0, mem_rw}, 32'h1);
    check_eq({tag, "_addr"}, mem_addr, 32'h80020000);
    tick();
    idle_in();
    check_eq({tag, "_stall"}, {31'h0, mem_stall}, 32'h1);
    check_eq({tag, "_wbv0"}, {31'h0, wb_valid}, 32'h0);
    tick();
    check_eq({tag, "_wbv"}, {31'h0, wb_valid}, 32'h1);
    check_eq({tag, "_res"}, wb_result, exp);
    check_eq({tag, "_rd"}, {27'h0, wb_rd}, 32'd7);
    check_eq({tag, "_we"}, {31'h0, wb_reg_write}, 32'h1);
    check_eq({tag, "_stall1"}, {31'h0, mem_stall}, 32'h0);
  endtask

  task automatic do_err(input string tag, input mem_op_t op, input logic [31:0] addr);
    drive(op, addr, 32'h0, 5'd9, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check_eq({tag, "_noen"}, {31'h0, mem_enable}, 32'h0);
    tick();
    idle_in();
    check_eq({tag, "_err"}, {31'h0, addr_err}, 32'h1);
    check_eq({tag, "_wbv"}, {31'h0, wb_valid}, 32'h1);
    check_eq({tag, "_we"}, {31'h0, wb_reg_write}, 32'h0);
    check_eq({tag, "_stall"}, {31'h0, mem_stall}, 32'h0);
    tick();
    check_eq({tag, "_errpulse"}, {31'h0, addr_err}, 32'h0);
  endtask

  task automatic do_rmw(input string tag, input mem_op_t op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic fl, input logic [3:0] idx,
                        input logic [31:0] exp);
    drive(op, addr, sdata, 5'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check_eq({tag, "_rd_en"}, {30'h0, mem_enable, mem_rw}, 32'h3);
    tick();
    idle_in();
    flush = fl;
    check_eq({tag, "_stall"}, {31'h0, mem_stall}, 32'h1);
    check_eq({tag, "_wr_en"}, {30'h0, mem_enable, mem_rw}, 32'h2);
    check_eq({tag, "_wdata"}, mem_wdata, exp);
    tick();
    flush = 1'b0;
    check_eq({tag, "_mem"}, mem[idx], exp);
    check_eq({tag, "_wbv"}, {31'h0, wb_valid}, 32'h1);
    check_eq({tag, "_we"}, {31'h0, wb_reg_write}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0]    = 32'h8899AABB;
    mem[2]    = 32'h11223344;
    mem_rdata = 32'h0;
    idle_in();
    ex_addr       = 32'h0;
    ex_store_data = 32'h0;
    ex_rd         = 5'd0;
    ex_reg_write  = 1'b0;
    wb_fwd_data   = 32'h0;

    #12;
    check_eq("rst_wbv", {31'h0, wb_valid}, 32'h0);
    check_eq("rst_we", {31'h0, wb_reg_write}, 32'h0);
    check_eq("rst_err", {31'h0, addr_err}, 32'h0);
    check_eq("rst_rd", {27'h0, wb_rd}, 32'h0);
    check_eq("rst_res", wb_result, 32'h0);
    check_eq("rst_en_rw", {30'h0, mem_enable, mem_rw}, 32'h1);
    check_eq("rst_stall", {31'h0, mem_stall}, 32'h0);
    check_eq("size", {30'h0, mem_access_size}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    do_load("lb", OpLb, 32'h80020001, 32'hFFFFFF99);
    tick();
    check_eq("lb_pulse", {31'h0, wb_valid}, 32'h0);
    do_load("lbu", OpLbu, 32'h80020001, 32'h00000099);
    do_load("lh", OpLh, 32'h80020002, 32'hFFFFAABB);
    do_load("lhu", OpLhu, 32'h80020002, 32'h0000AABB);
    do_load("lb3", OpLb, 32'h80020003, 32'hFFFFFFBB);
    do_err("lh_mis", OpLh, 32'h80020001);
    do_err("lw_mis", OpLw, 32'h80020002);
    do_err("lw_hi", OpLw, 32'h80120000);
    do_err("lw_lo", OpLw, 32'h8001FFFC);

    do_rmw("sb", OpSb, 32'h80020002, 32'h12345678, 1'b0, 4'd0, 32'h889978BB);
    do_rmw("sh", OpSh, 32'h80020000, 32'h0000CAFE, 1'b0, 4'd0, 32'hCAFE78BB);

    // Word store with WB forwarding lands at the accept edge.
    drive(OpSw, 32'h80020004, 32'h0, 5'd1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    #1;
    check_eq("sw_en_rw", {30'h0, mem_enable, mem_rw}, 32'h2);
    check_eq("sw_wdata", mem_wdata, 32'hDEADBEEF);
    check_eq("sw_addr", mem_addr, 32'h80020004);
    tick();
    idle_in();
    check_eq("sw_mem", mem[1], 32'hDEADBEEF);
    check_eq("sw_stall", {31'h0, mem_stall}, 32'h0);
    check_eq("sw_wbv", {31'h0, wb_valid}, 32'h1);
    check_eq("sw_we", {31'h0, wb_reg_write}, 32'h0);

    // Load flushed while waiting for data.
    drive(OpLw, 32'h80020004, 32'h0, 5'd6, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    idle_in();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("lw_flush_wbv", {31'h0, wb_valid}, 32'h0);
    check_eq("lw_flush_we", {31'h0, wb_reg_write}, 32'h0);
    check_eq("lw_flush_stall", {31'h0, mem_stall}, 32'h0);

    do_rmw("sb_flush", OpSb, 32'h80020007, 32'h000000AA, 1'b1, 4'd1, 32'hDEADBEAA);

    // Flush on the accept edge kills the instruction outright.
    drive(OpSw, 32'h80020008, 32'h55555555, 5'd1, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    check_eq("kill_noen", {31'h0, mem_enable}, 32'h0);
    tick();
    idle_in();
    check_eq("kill_wbv", {31'h0, wb_valid}, 32'h0);
    check_eq("kill_mem", mem[2], 32'h11223344);

    // NONE, LW, NONE back to back: wb_valid 1,0,1,1 with EX held once.
    drive(OpNone, 32'h00000005, 32'h0, 5'd3, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check_eq("none_noen", {31'h0, mem_enable}, 32'h0);
    tick();
    check_eq("b2b_v0", {31'h0, wb_valid}, 32'h1);
    check_eq("b2b_res0", wb_result, 32'h00000005);
    check_eq("b2b_rd0", {27'h0, wb_rd}, 32'd3);
    check_eq("b2b_we0", {31'h0, wb_reg_write}, 32'h1);
    drive(OpLw, 32'h80020000, 32'h0, 5'd4, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check_eq("b2b_v1", {31'h0, wb_valid}, 32'h0);
    check_eq("b2b_stall", {31'h0, mem_stall}, 32'h1);
    tick();
    check_eq("b2b_v2", {31'h0, wb_valid}, 32'h1);
    check_eq("b2b_res2", wb_result, 32'hCAFE78BB);
    check_eq("b2b_rd2", {27'h0, wb_rd}, 32'd4);
    drive(OpNone, 32'h00000007, 32'h0, 5'd5, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    idle_in();
    check_eq("b2b_v3", {31'h0, wb_valid}, 32'h1);
    check_eq("b2b_res3", wb_result, 32'h00000007);
    check_eq("b2b_we3", {31'h0, wb_reg_write}, 32'h0);
    tick();
    check_eq("b2b_v4", {31'h0, wb_valid}, 32'h0);

    // Reset in the middle of a read-modify-write abandons the write.
    drive(OpSb, 32'h80020008, 32'h000000FF, 5'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    idle_in();
    check_eq("rrst_in_rmw", {31'h0, mem_stall}, 32'h1);
    reset_n = 1'b0;
    #1;
    check_eq("rrst_en_rw", {30'h0, mem_enable, mem_rw}, 32'h1);
    check_eq("rrst_stall", {31'h0, mem_stall}, 32'h0);
    check_eq("rrst_wbv", {31'h0, wb_valid}, 32'h0);
    check_eq("rrst_res", wb_result, 32'h0);
    check_eq("rrst_rd", {27'h0, wb_rd}, 32'h0);
    tick();
    check_eq("rrst_mem", mem[2], 32'h11223344);
    reset_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
